// File: rtl/page_req_pkg.sv
// rtl/page_req_pkg.sv - default widths, packet field offsets and FSM states for page_requester
package page_req_pkg;

   // Default geometry of the requester and its local queue.
   localparam int DEF_NODE_W = 2;
   localparam int DEF_REQ_W  = 7;
   localparam int DEF_TAG_W  = 3;
   localparam int DEF_DEPTH  = 4;

   // Packet layout {id, request_id, tag}, MSB first, for the default widths.
   localparam int TAG_LSB  = 0;
   localparam int REQ_LSB  = TAG_LSB + DEF_TAG_W;
   localparam int NODE_LSB = REQ_LSB + DEF_REQ_W;
   localparam int PKT_W    = NODE_LSB + DEF_NODE_W;

   // IDLE: queue empty; SEND: write whenever allowed; THROTTLE: forced one-cycle gap.
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SEND     = 2'd1,
      ST_THROTTLE = 2'd2
   } req_state_t;

endpackage

// File: rtl/req_queue.sv
// rtl/req_queue.sv - DEPTH-entry circular buffer with occupancy count
module req_queue
   import page_req_pkg::*;
#(
   parameter int WIDTH = DEF_REQ_W,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Storage carries no reset; entries are only meaningful below count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/page_requester.sv
// rtl/page_requester.sv - queues page requests and streams {id, request_id, tag} downstream; optional REQ_DEDUP_EN drops back-to-back repeats
module page_requester
   import page_req_pkg::*;
#(
   parameter int NODE_W = DEF_NODE_W,
   parameter int REQ_W  = DEF_REQ_W,
   parameter int TAG_W  = DEF_TAG_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NODE_W-1:0]               id,
   input  logic                            req_valid,
   input  logic [REQ_W-1:0]                request_id,
   output logic                            req_ready,
   input  logic                            full_req,
   input  logic                            almost_full_req,
   output logic [NODE_W+REQ_W+TAG_W-1:0]   dataIn_req,
   output logic                            write_req,
   output logic [$clog2(DEPTH+1)-1:0]      pending
);

   localparam int CNT_W = $clog2(DEPTH+1);

   logic             accept;
   logic             push;
   logic             pop;
   logic             q_empty;
   logic [REQ_W-1:0] head;
   logic [CNT_W-1:0] count_after;
   logic [TAG_W-1:0] tag;
   req_state_t       state;
   req_state_t       state_nxt;

   assign req_ready = reset && (pending < CNT_W'(DEPTH));
   assign accept    = req_valid && req_ready;
   assign q_empty   = (pending == '0);

`ifdef REQ_DEDUP_EN
   logic [REQ_W-1:0] last_id;
   logic             last_vld;

   // Remember the most recent accepted id so an immediate repeat is handshaken but dropped.
   always_ff @(posedge clk) begin
      if (!reset) begin
         last_id  <= '0;
         last_vld <= 1'b0;
      end else if (accept) begin
         last_id  <= request_id;
         last_vld <= 1'b1;
      end
   end

   assign push = accept && !(last_vld && (last_id == request_id));
`else
   assign push = accept;
`endif

   req_queue #(
      .WIDTH (REQ_W),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (request_id),
      .pop       (pop),
      .head      (head),
      .count     (pending)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Write decision and next state; a write taken with almost_full_req high forces a gap cycle.
   always_comb begin
      pop         = 1'b0;
      state_nxt   = state;
      count_after = pending;
      pop         = !q_empty && !full_req && (state != ST_THROTTLE);
      count_after = pending + CNT_W'(push) - CNT_W'(pop);
      case (state)
         ST_THROTTLE: state_nxt = (count_after != '0) ? ST_SEND : ST_IDLE;
         default: begin
            if (pop && almost_full_req) begin
               state_nxt = ST_THROTTLE;
            end else if (count_after != '0) begin
               state_nxt = ST_SEND;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
      endcase
   end

   // Registered downstream strobe and packet; the packet holds between writes.
   always_ff @(posedge clk) begin
      if (!reset) begin
         write_req  <= 1'b0;
         dataIn_req <= '0;
         tag        <= '0;
      end else begin
         write_req <= pop;
         if (pop) begin
            dataIn_req <= {id, head, tag};
            tag        <= tag + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_page_requester.sv
// tb/tb_page_requester.sv - directed and randomized checks of page_requester against a queue-based model
module tb_page_requester;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  id;
   logic        req_valid;
   logic [6:0]  request_id;
   logic        req_ready;
   logic        full_req;
   logic        almost_full_req;
   logic [11:0] dataIn_req;
   logic        write_req;
   logic [2:0]  pending;

   int          total = 0;
   int          bad   = 0;
   int          wcount = 0;

   int          mq[$];
   int          m_tag;
   logic        m_gap;
   logic [11:0] m_data;
   logic        m_write;
`ifdef REQ_DEDUP_EN
   int          m_last;
   logic        m_last_vld;
`endif

   always #5 clk = ~clk;

   page_requester #(
      .NODE_W (2),
      .REQ_W  (7),
      .TAG_W  (3),
      .DEPTH  (DEPTH)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .id              (id),
      .req_valid       (req_valid),
      .request_id      (request_id),
      .req_ready       (req_ready),
      .full_req        (full_req),
      .almost_full_req (almost_full_req),
      .dataIn_req      (dataIn_req),
      .write_req       (write_req),
      .pending         (pending)
   );

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_tag   = 0;
      m_gap   = 1'b0;
      m_data  = '0;
      m_write = 1'b0;
`ifdef REQ_DEDUP_EN
      m_last     = 0;
      m_last_vld = 1'b0;
`endif
   endtask

   task automatic do_reset(input int cycles);
      reset           = 1'b0;
      req_valid       = 1'b0;
      full_req        = 1'b0;
      almost_full_req = 1'b0;
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
      model_reset();
      chk("rst_ready",   32'(req_ready),  32'd0);
      chk("rst_write",   32'(write_req),  32'd0);
      chk("rst_data",    32'(dataIn_req), 32'd0);
      chk("rst_pending", 32'(pending),    32'd0);
      reset = 1'b1;
   endtask

   task automatic step(input logic v, input int rid, input logic f, input logic a);
      bit acc;
      bit wr;
      req_valid       = v;
      request_id      = rid[6:0];
      full_req        = f;
      almost_full_req = a;
      #1;
      chk("ready", 32'(req_ready), 32'(mq.size() < DEPTH));
      @(posedge clk);
      acc = v && (mq.size() < DEPTH);
      wr  = (mq.size() > 0) && !f && !m_gap;
      if (wr) begin
         m_data = 12'((int'(id) << 10) | (mq.pop_front() << 3) | m_tag);
         m_tag  = (m_tag + 1) % 8;
      end
      m_write = wr;
      m_gap   = wr && a;
      if (acc) begin
`ifdef REQ_DEDUP_EN
         if (!(m_last_vld && m_last == (rid % 128))) mq.push_back(rid % 128);
         m_last_vld = 1'b1;
         m_last     = rid % 128;
`else
         mq.push_back(rid % 128);
`endif
      end
      #1;
      chk("write_req",  32'(write_req),  32'(m_write));
      chk("dataIn_req", 32'(dataIn_req), 32'(m_data));
      chk("pending",    32'(pending),    32'(mq.size()));
      if (write_req === 1'b1) wcount++;
   endtask

   initial begin
      reset           = 1'b0;
      id              = 2'd0;
      req_valid       = 1'b0;
      request_id      = '0;
      full_req        = 1'b0;
      almost_full_req = 1'b0;
      model_reset();

      do_reset(2);

      // single request: next cycle writes {2, 20, 0}
      id = 2'd2;
      step(1'b1, 20, 1'b0, 1'b0);
      step(1'b0, 0, 1'b0, 1'b0);
      chk("single_write", 32'(write_req),  32'd1);
      chk("single_data",  32'(dataIn_req), 32'h8A0);
      repeat (2) step(1'b0, 0, 1'b0, 1'b0);

      // downstream full: queue fills to DEPTH, then drains in order with tags 0..3
      do_reset(1);
      id = 2'd1;
      for (int i = 0; i < 5; i++) step(1'b1, 10 + i, 1'b1, 1'b0);
      chk("full_pending", 32'(pending),   32'd4);
      chk("full_ready",   32'(req_ready), 32'd0);
      chk("full_nowrite", 32'(write_req), 32'd0);
      repeat (6) step(1'b0, 0, 1'b0, 1'b0);

      // almost full: three queued entries leave on alternate cycles
      do_reset(1);
      for (int i = 0; i < 3; i++) step(1'b1, 30 + i, 1'b1, 1'b0);
      repeat (7) step(1'b0, 0, 1'b0, 1'b1);

      // nine writes wrap the tag through 7 back to 0
      do_reset(1);
      id = 2'd3;
      for (int i = 0; i < 9; i++) step(1'b1, 40 + i, 1'b0, 1'b0);
      repeat (3) step(1'b0, 0, 1'b0, 1'b0);

      // reset with three pending entries discards them and restarts the tag
      for (int i = 0; i < 3; i++) step(1'b1, 50 + i, 1'b1, 1'b0);
      chk("mid_pending", 32'(pending), 32'd3);
      do_reset(1);
      step(1'b1, 5, 1'b0, 1'b0);
      step(1'b0, 0, 1'b0, 1'b0);
      chk("mid_tag0", 32'(dataIn_req[2:0]), 32'd0);

      // repeated id: deduplicated only when the feature is built in
      do_reset(1);
      wcount = 0;
      step(1'b1, 63, 1'b0, 1'b0);
      step(1'b1, 63, 1'b0, 1'b0);
      step(1'b1, 0, 1'b0, 1'b0);
      repeat (4) step(1'b0, 0, 1'b0, 1'b0);
`ifdef REQ_DEDUP_EN
      chk("dedup_writes", 32'(wcount), 32'd2);
`else
      chk("dedup_writes", 32'(wcount), 32'd3);
`endif

      // randomized traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         id = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 99) == 0) begin
            do_reset(1);
         end else begin
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 127)),
                 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 2) == 0));
         end
      end
      repeat (8) step(1'b0, 0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
